hms_clock_core: RTL and testbench

//  Hardware time-of-day core for the timer-based digital clock. Sits between the Nios system's

---
 rtl/hms_clock_core.sv | 148 ++++++++++++++
 tb/tb_hms_clock_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hms_clock_core.sv
// Time-of-day core: 1 s prescaler, BCD HH:MM:SS (24 h) counter with validated
// software writes, sticky alarm flag and registered seven-segment drive.
module hms_clock_core #(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        run,
  input  logic        time_wr,
  input  logic [23:0] time_wdata,
  input  logic        alarm_wr,
  input  logic [23:0] alarm_wdata,
  input  logic        alarm_en,
  input  logic        alarm_clr,
  output logic [23:0] time_bcd,
  output logic        sec_tick,
  output logic        wr_err,
  output logic        alarm_flag,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       SEG_ZERO = 7'b1000000;

  logic [DIV_W-1:0] presc;
  logic [23:0]      time_q;
  logic [23:0]      alarm_q;
  logic             tick;
  logic             time_ok;
  logic             alarm_ok;
  logic [23:0]      time_next;

  function automatic logic bcd_valid(input logic [23:0] t);
    logic [3:0] ht, ho, mt, mo, st, so;
    {ht, ho, mt, mo, st, so} = t;
    bcd_valid = (ho <= 4'd9) && (mo <= 4'd9) && (so <= 4'd9) &&
                (st <= 4'd5) && (mt <= 4'd5) && (ht <= 4'd2) &&
                !((ht == 4'd2) && (ho > 4'd3));
  endfunction

  // Ripple-carry through the digits; only called on states already known valid.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] ht, ho, mt, mo, st, so;
    {ht, ho, mt, mo, st, so} = t;
    if (so != 4'd9) so = so + 4'd1;
    else begin
      so = 4'd0;
      if (st != 4'd5) st = st + 4'd1;
      else begin
        st = 4'd0;
        if (mo != 4'd9) mo = mo + 4'd1;
        else begin
          mo = 4'd0;
          if (mt != 4'd5) mt = mt + 4'd1;
          else begin
            mt = 4'd0;
            if (ht == 4'd2 && ho == 4'd3) begin
              ht = 4'd0;
              ho = 4'd0;
            end else if (ho == 4'd9) begin
              ho = 4'd0;
              ht = ht + 4'd1;
            end else ho = ho + 4'd1;
          end
        end
      end
    end
    bcd_inc = {ht, ho, mt, mo, st, so};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign tick      = run && (presc == LAST);
  assign time_ok   = bcd_valid(time_wdata);
  assign alarm_ok  = bcd_valid(alarm_wdata);
  assign time_next = bcd_inc(time_q);
  assign time_bcd  = time_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      presc      <= '0;
      time_q     <= '0;
      alarm_q    <= '0;
      sec_tick   <= 1'b0;
      wr_err     <= 1'b0;
      alarm_flag <= 1'b0;
      hex0       <= SEG_ZERO;
      hex1       <= SEG_ZERO;
      hex2       <= SEG_ZERO;
      hex3       <= SEG_ZERO;
      hex4       <= SEG_ZERO;
      hex5       <= SEG_ZERO;
    end else begin
      sec_tick <= 1'b0;
      // A valid software write pre-empts a coincident tick and restarts the second.
      if (time_wr && time_ok) begin
        time_q <= time_wdata;
        presc  <= '0;
      end else if (tick) begin
        time_q   <= time_next;
        presc    <= '0;
        sec_tick <= 1'b1;
      end else if (run) begin
        presc <= presc + 1'b1;
      end

      if (alarm_wr && alarm_ok) alarm_q <= alarm_wdata;

      if (time_wr || alarm_wr)
        wr_err <= (time_wr && !time_ok) || (alarm_wr && !alarm_ok);

      if (tick && !(time_wr && time_ok) && alarm_en && (time_next == alarm_q))
        alarm_flag <= 1'b1;
      else if (alarm_clr)
        alarm_flag <= 1'b0;

      hex0 <= seg7(time_q[3:0]);
      hex1 <= seg7(time_q[7:4]);
      hex2 <= seg7(time_q[11:8]);
      hex3 <= seg7(time_q[15:12]);
      hex4 <= seg7(time_q[19:16]);
      hex5 <= seg7(time_q[23:20]);
    end
  end

endmodule

// File: tb/tb_hms_clock_core.sv
// Self-checking bench for hms_clock_core: directed scenarios plus random stimulus
// compared every cycle against a seconds-of-day reference model.
module tb_hms_clock_core;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;
  localparam int DAY     = 86400;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        run, time_wr, alarm_wr, alarm_en, alarm_clr;
  logic [23:0] time_wdata, alarm_wdata;
  logic [23:0] time_bcd;
  logic        sec_tick, wr_err, alarm_flag;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  hms_clock_core #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .run(run),
    .time_wr(time_wr), .time_wdata(time_wdata),
    .alarm_wr(alarm_wr), .alarm_wdata(alarm_wdata),
    .alarm_en(alarm_en), .alarm_clr(alarm_clr),
    .time_bcd(time_bcd), .sec_tick(sec_tick), .wr_err(wr_err), .alarm_flag(alarm_flag),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: time and alarm as seconds since midnight.
  int m_secs, m_alarm, m_cnt, m_hex_secs;
  bit m_tick, m_err, m_flag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [23:0] b);
    for (int i = 0; i < 6; i++) if (b[i*4 +: 4] > 9) return 0;
    return (b[23:20] * 10 + b[19:16] < 24) && (b[15:12] * 10 + b[11:8] < 60) &&
           (b[7:4] * 10 + b[3:0] < 60);
  endfunction

  function automatic int to_secs(input logic [23:0] b);
    return (b[23:20] * 10 + b[19:16]) * 3600 + (b[15:12] * 10 + b[11:8]) * 60 +
           b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [41:0] hex_of(input int s);
    logic [23:0] b;
    b = to_bcd(s);
    return {seg(b[23:20]), seg(b[19:16]), seg(b[15:12]), seg(b[11:8]), seg(b[7:4]), seg(b[3:0])};
  endfunction

  function automatic bit tick_pending();
    return run && (m_cnt == CLK_DIV - 1);
  endfunction

  task automatic model_step();
    bit tk, tv, av, set;
    tv = bcd_ok(time_wdata);
    av = bcd_ok(alarm_wdata);
    tk = tick_pending();
    if (!reset_reset_n) begin
      m_secs = 0; m_alarm = 0; m_cnt = 0; m_tick = 0; m_err = 0; m_flag = 0; m_hex_secs = 0;
      return;
    end
    m_hex_secs = m_secs;
    set = 0;
    m_tick = 0;
    if (time_wr && tv) begin
      m_secs = to_secs(time_wdata); m_cnt = 0;
    end else if (tk) begin
      m_secs = (m_secs + 1) % DAY; m_cnt = 0; m_tick = 1;
      set = alarm_en && (m_secs == m_alarm);
    end else if (run) m_cnt++;
    if (set) m_flag = 1;
    else if (alarm_clr) m_flag = 0;
    if (alarm_wr && av) m_alarm = to_secs(alarm_wdata);
    if (time_wr || alarm_wr) m_err = (time_wr && !tv) || (alarm_wr && !av);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_clk);
    #1;
    check("time_bcd", 64'(time_bcd), 64'(to_bcd(m_secs)));
    check("sec_tick", 64'(sec_tick), 64'(m_tick));
    check("wr_err", 64'(wr_err), 64'(m_err));
    check("alarm_flag", 64'(alarm_flag), 64'(m_flag));
    check("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hex_of(m_hex_secs)));
  endtask

  task automatic write_time(input logic [23:0] v);
    time_wr = 1; time_wdata = v;
    cycle();
    time_wr = 0;
  endtask

  task automatic do_reset();
    reset_reset_n = 0;
    cycle(); cycle();
    reset_reset_n = 1;
  endtask

  initial begin
    int n, ticks;
    reset_reset_n = 1; run = 0; time_wr = 0; alarm_wr = 0; alarm_en = 0; alarm_clr = 0;
    time_wdata = '0; alarm_wdata = '0;
    m_secs = 0; m_alarm = 0; m_cnt = 0; m_tick = 0; m_err = 0; m_flag = 0; m_hex_secs = 0;

    // T1: reset state
    do_reset();
    check("t1_time", 64'(time_bcd), 64'h0);
    check("t1_hex0", 64'(hex0), 64'h40);
    check("t1_hex5", 64'(hex5), 64'h40);

    // T2: ten ticks, then a frozen stretch mid-count
    run = 1;
    for (int i = 0; i < 10 * CLK_DIV; i++) cycle();
    check("t2_ten_ticks", 64'(time_bcd), 64'h000010);
    cycle(); cycle();
    run = 0;
    for (int i = 0; i < 7; i++) cycle();
    run = 1;
    ticks = 0;
    for (int i = 0; i < CLK_DIV; i++) begin cycle(); ticks += sec_tick; end
    check("t2_resume_ticks", 64'(ticks), 64'd1);

    // T3: midnight and hour-tens rollover
    write_time(24'h235959);
    while (!tick_pending()) cycle();
    cycle();
    check("t3_midnight", 64'(time_bcd), 64'h000000);
    cycle();
    check("t3_hex_zero", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), {22'd0, {6{7'h40}}});
    write_time(24'h095959);
    while (!tick_pending()) cycle();
    cycle();
    check("t3_ten_hours", 64'(time_bcd), 64'h100000);

    // T4: rejected writes leave time alone
    run = 0;
    write_time(24'h245900); check("t4_err_hour", 64'(wr_err), 64'd1);
    write_time(24'h126000); check("t4_err_min", 64'(wr_err), 64'd1);
    write_time(24'h00000A); check("t4_err_digit", 64'(wr_err), 64'd1);
    check("t4_unchanged", 64'(time_bcd), 64'h100000);
    write_time(24'h120000);
    check("t4_loaded", 64'(time_bcd), 64'h120000);
    check("t4_err_clear", 64'(wr_err), 64'd0);

    // T5: write colliding with a tick
    run = 1;
    while (!tick_pending()) cycle();
    write_time(24'h010203);
    check("t5_time", 64'(time_bcd), 64'h010203);
    check("t5_no_tick", 64'(sec_tick), 64'd0);
    n = 0;
    while (!sec_tick && n < 20) begin cycle(); n++; end
    check("t5_tick_latency", 64'(n), 64'(CLK_DIV));

    // T6: alarm set/clear collision
    do_reset();
    alarm_wr = 1; alarm_wdata = 24'h000002; alarm_en = 1; run = 1;
    cycle();
    alarm_wr = 0;
    n = 0;
    while (!(tick_pending() && m_secs == 1) && n < 50) begin cycle(); n++; end
    alarm_clr = 1;
    cycle();
    check("t6_set_wins", 64'(alarm_flag), 64'd1);
    check("t6_time", 64'(time_bcd), 64'h000002);
    cycle();
    check("t6_cleared", 64'(alarm_flag), 64'd0);
    alarm_clr = 0;

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      reset_reset_n = ($urandom_range(999) != 0);
      run       = ($urandom_range(9) != 0);
      alarm_en  = ($urandom_range(3) != 0);
      alarm_clr = ($urandom_range(19) == 0);
      time_wr   = ($urandom_range(29) == 0);
      alarm_wr  = ($urandom_range(29) == 0);
      time_wdata  = ($urandom_range(3) == 0) ? 24'($urandom) : to_bcd($urandom_range(DAY - 1));
      alarm_wdata = ($urandom_range(3) == 0) ? 24'($urandom)
                                             : to_bcd((m_secs + $urandom_range(3)) % DAY);
      if ($urandom_range(200) == 0) time_wdata = 24'h235958;
      cycle();
    end
    reset_reset_n = 1; time_wr = 0; alarm_wr = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
